shift_arb_2ch: RTL and testbench

//   Shares one 8-bit rotate unit between two requesters (ch0, ch1) with round-robin arbitration.

---
 rtl/shift_arb_pkg.sv | 21 ++
 rtl/rot_unit_8b.sv | 20 ++
 rtl/shift_arb_2ch.sv | 114 +++++++++++
 tb/tb_shift_arb_2ch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the two-channel rotate arbiter.
package shift_arb_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/rot_unit_8b.sv
// Combinational 8-bit rotator: three log stages rotate right; a left rotate
// mirrors the operand before and after the same right-rotate network.
module rot_unit_8b
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              lr_i,
  input  logic [AMT_W-1:0]  amt_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] s0, s1, s2, s3;

  assign s0     = (lr_i == DIR_L) ? bit_rev(data_i) : data_i;
  assign s1     = amt_i[0] ? {s0[0],   s0[7:1]} : s0;
  assign s2     = amt_i[1] ? {s1[1:0], s1[7:2]} : s1;
  assign s3     = amt_i[2] ? {s2[3:0], s2[7:4]} : s2;
  assign data_o = (lr_i == DIR_L) ? bit_rev(s3) : s3;

endmodule

// File: rtl/shift_arb_2ch.sv
// Round-robin arbiter sharing one rotator between two valid/ready requesters.
// Define SHIFT_ARB_STATS_EN to add per-channel grant counters gnt_cnt0/gnt_cnt1.
module shift_arb_2ch
  import shift_arb_pkg::*;
#(
  parameter logic RR_INIT = 1'b0,
  parameter int   STATS_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lr,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lr,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] gnt_cnt0,
  output logic [STATS_W-1:0] gnt_cnt1
`endif
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              id_q, id_d;

  logic              acc, win, grant;
  logic [DATA_W-1:0] op_data, rot_out;
  logic              op_lr;
  logic [AMT_W-1:0]  op_amt;

  // Operands follow the winner, so a single rotator serves both channels.
  assign op_data = win ? req1_data : req0_data;
  assign op_lr   = win ? req1_lr   : req0_lr;
  assign op_amt  = win ? req1_amt  : req0_amt;

  rot_unit_8b u_rot (
    .data_i (op_data),
    .lr_i   (op_lr),
    .amt_i  (op_amt),
    .data_o (rot_out)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    prio_d  = prio_q;
    data_d  = data_q;
    id_d    = id_q;

    acc   = (state_q == ST_IDLE) | rsp_ready;
    win   = (req0_valid & req1_valid) ? prio_q : req1_valid;
    grant = acc & (req0_valid | req1_valid) & ~reset;

    if (grant) begin
      state_d = ST_FULL;
      prio_d  = ~win;
      data_d  = rot_out;
      id_d    = win;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  assign req0_ready = grant & ~win;
  assign req1_ready = grant &  win;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      prio_q  <= RR_INIT;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [STATS_W-1:0] gnt_cnt0_q, gnt_cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (req0_ready) gnt_cnt0_q <= gnt_cnt0_q + STATS_W'(1);
      if (req1_ready) gnt_cnt1_q <= gnt_cnt1_q + STATS_W'(1);
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_shift_arb_2ch.sv
// Directed bench for shift_arb_2ch: reset, rotation, round-robin, backpressure,
// full rotate sweep and reset during a held result.
module tb_shift_arb_2ch;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_lr;
  logic [7:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_lr;
  logic [7:0] req1_data;
  logic [2:0] req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  shift_arb_2ch #(.RR_INIT(1'b0), .STATS_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_lr    (req0_lr),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_lr    (req1_lr),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic lr, input int amt);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = lr ? d[(i - amt + 8) % 8] : d[(i + amt) % 8];
    return r;
  endfunction

  task automatic set_ch0(input logic v, input logic [7:0] d, input logic lr, input logic [2:0] a);
    req0_valid = v; req0_data = d; req0_lr = lr; req0_amt = a;
  endtask

  task automatic set_ch1(input logic v, input logic [7:0] d, input logic lr, input logic [2:0] a);
    req1_valid = v; req1_data = d; req1_lr = lr; req1_amt = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b1;
    set_ch0(1'b1, 8'h11, 1'b0, 3'd1);
    set_ch1(1'b1, 8'h22, 1'b0, 3'd1);
    #1;

    // 1: reset state; requests offered during reset are refused
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    tick();
    tick();
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_rdy0b", req0_ready, 0);
`ifdef SHIFT_ARB_STATS_EN
    check("rst_cnt0", gnt_cnt0, 0);
    check("rst_cnt1", gnt_cnt1, 0);
`endif

    // 2: ch0 alone, right then left by 1
    reset = 1'b0;
    set_ch1(1'b0, 8'h00, 1'b0, 3'd0);
    set_ch0(1'b1, 8'h81, 1'b0, 3'd1);
    #1;
    check("c0_rdy0", req0_ready, 1);
    check("c0_rdy1", req1_ready, 0);
    tick();
    check("c0_valid", rsp_valid, 1);
    check("c0_rr_data", rsp_data, 8'hC0);
    check("c0_rr_id", rsp_id, 0);
    set_ch0(1'b1, 8'h81, 1'b1, 3'd1);
    tick();
    check("c0_rl_data", rsp_data, 8'h03);
    check("c0_rl_id", rsp_id, 0);

    // 3: both channels always valid, grants alternate from RR_INIT
    do_reset();
    set_ch0(1'b1, 8'h0F, 1'b0, 3'd4);
    set_ch1(1'b1, 8'h01, 1'b1, 3'd7);
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_rdy0", req0_ready, (i % 2 == 0));
      check("rr_rdy1", req1_ready, (i % 2 == 1));
      tick();
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, i % 2);
      check("rr_data", rsp_data, (i % 2 == 1) ? 8'h80 : 8'hF0);
    end
`ifdef SHIFT_ARB_STATS_EN
    check("rr_cnt0", gnt_cnt0, 4);
    check("rr_cnt1", gnt_cnt1, 4);
`endif

    // 4: backpressure holds the ch1 result; ch0 is next in line
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rdy0", req0_ready, 0);
      check("bp_rdy1", req1_ready, 0);
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 1);
      check("bp_data", rsp_data, 8'h80);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_rdy0", req0_ready, 1);
    check("bp_rel_rdy1", req1_ready, 0);
    tick();
    check("bp_rel_id", rsp_id, 0);
    check("bp_rel_data", rsp_data, 8'hF0);
    set_ch0(1'b0, 8'h00, 1'b0, 3'd0);
    set_ch1(1'b0, 8'h00, 1'b0, 3'd0);
    tick();
    check("drain_valid", rsp_valid, 0);

    // 5: amt=0 passes through; then full sweep, lr selects the channel
    set_ch0(1'b1, 8'hA5, 1'b0, 3'd0);
    tick();
    check("amt0_r", rsp_data, 8'hA5);
    set_ch0(1'b1, 8'hA5, 1'b1, 3'd0);
    tick();
    check("amt0_l", rsp_data, 8'hA5);
    set_ch0(1'b0, 8'h00, 1'b0, 3'd0);
    for (int d = 0; d < 256; d++) begin
      for (int a = 0; a < 8; a++) begin
        for (int lr = 0; lr < 2; lr++) begin
          if (lr == 0) begin
            set_ch0(1'b1, 8'(d), 1'b0, 3'(a));
            set_ch1(1'b0, 8'h00, 1'b0, 3'd0);
          end else begin
            set_ch0(1'b0, 8'h00, 1'b0, 3'd0);
            set_ch1(1'b1, 8'(d), 1'b1, 3'(a));
          end
          tick();
          check("sweep", {23'd0, rsp_id, rsp_data}, {23'd0, 1'(lr), ref_rot(8'(d), 1'(lr), a)});
        end
      end
    end

    // 6: reset while a result is held and both channels request
    do_reset();
    set_ch0(1'b1, 8'h0F, 1'b0, 3'd4);
    set_ch1(1'b1, 8'h01, 1'b1, 3'd7);
    tick();
    rsp_ready = 1'b0;
    tick();
    check("mr_held", rsp_valid, 1);
    check("mr_held_id", rsp_id, 0);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("mr_rdy0", req0_ready, 0);
    check("mr_rdy1", req1_ready, 0);
    tick();
    check("mr_valid", rsp_valid, 0);
    check("mr_data", rsp_data, 0);
`ifdef SHIFT_ARB_STATS_EN
    check("mr_cnt1", gnt_cnt1, 0);
`endif
    reset = 1'b0;
    #1;
    check("mr_post_rdy0", req0_ready, 1);
    check("mr_post_rdy1", req1_ready, 0);
    tick();
    check("mr_post_id", rsp_id, 0);
    check("mr_post_data", rsp_data, 8'hF0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
